// File: rtl/matrix_io_ctrl.sv
// Serial FP8 front-end for a 3x3 matrix multiplier: loads A/B bytes, pulses mm_start,
// waits RUN_CYCLES, captures C and streams it out. Optional macro: MATRIX_IO_ZERO_CANON_EN.
module matrix_io_ctrl #(
  parameter int RUN_CYCLES = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [71:0] a_flat,
  output logic [71:0] b_flat,
  output logic        mm_start,
  input  logic [71:0] c_flat,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_SEND
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  in_idx_q, in_idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  out_idx_q, out_idx_d;
  logic [71:0] a_q, a_d;
  logic [71:0] b_q, b_d;
  logic [71:0] shadow_q, shadow_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        mm_start_q, mm_start_d;
  logic        busy_q, busy_d;
  logic        in_fire, out_fire;

  logic [7:0]  shadow_byte [9];

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_shadow_bytes
      assign shadow_byte[gi] = shadow_q[8*(8-gi) +: 8];
    end
  endgenerate

  function automatic logic [7:0] canon(input logic [7:0] b);
`ifdef MATRIX_IO_ZERO_CANON_EN
    return (b == 8'h80) ? 8'h00 : b;
`else
    return b;
`endif
  endfunction

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d    = state_q;
    in_idx_d   = in_idx_q;
    cnt_d      = cnt_q;
    out_idx_d  = out_idx_q;
    a_d        = a_q;
    b_d        = b_q;
    shadow_d   = shadow_q;
    out_data_d = out_data_q;

    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          for (int i = 0; i < 9; i++) begin
            if (in_idx_q == 5'(i))     a_d[8*(8-i) +: 8] = in_data;
            if (in_idx_q == 5'(i + 9)) b_d[8*(8-i) +: 8] = in_data;
          end
          if (in_idx_q == 5'd17) begin
            in_idx_d = 5'd0;
            state_d  = S_START;
          end else begin
            in_idx_d = in_idx_q + 5'd1;
          end
        end
      end
      S_START: begin
        cnt_d   = 4'(RUN_CYCLES);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Counter enters at RUN_CYCLES, so WAIT spans exactly RUN_CYCLES cycles.
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        // out_data is registered, so the first byte comes straight from c_flat here.
        shadow_d   = c_flat;
        out_idx_d  = 4'd0;
        out_data_d = canon(c_flat[71:64]);
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (out_fire) begin
          if (out_idx_q == 4'd8) begin
            out_idx_d  = 4'd0;
            out_data_d = 8'h00;
            state_d    = S_LOAD;
          end else begin
            out_idx_d  = out_idx_q + 4'd1;
            out_data_d = canon(shadow_byte[out_idx_q + 4'd1]);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_SEND);
    mm_start_d  = (state_d == S_START);
    busy_d      = (state_d != S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      in_idx_q    <= 5'd0;
      cnt_q       <= 4'd0;
      out_idx_q   <= 4'd0;
      a_q         <= 72'd0;
      b_q         <= 72'd0;
      shadow_q    <= 72'd0;
      out_data_q  <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mm_start_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_idx_q    <= in_idx_d;
      cnt_q       <= cnt_d;
      out_idx_q   <= out_idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      mm_start_q  <= mm_start_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign a_flat    = a_q;
  assign b_flat    = b_q;
  assign mm_start  = mm_start_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/matrix_io_ctrl.md
MATRIX_IO_CTRL -- requirements
Module: matrix_io_ctrl

Interface
REQ-001 Parameter RUN_CYCLES, default 9: cycles waited after mm_start before sampling results; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 in_data  input  8  serial FP8 operand byte.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_ready  output  1  controller accepts in_data this cycle.
REQ-007 a_flat  output  72  A matrix to the multiplier, row-major, A00 in [71:64], A22 in [7:0].
REQ-008 b_flat  output  72  B matrix, same packing as a_flat.
REQ-009 mm_start  output  1  one-cycle pulse that restarts the multiplier schedule.
REQ-010 c_flat  input  72  C results from the multiplier, same packing.
REQ-011 out_data  output  8  serial FP8 result byte.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 busy  output  1  high in every state except LOAD.

Function
REQ-015 FSM states: LOAD, START, WAIT, CAPTURE, SEND; no other states reachable.
REQ-016 LOAD: in_ready=1; a byte is accepted on a cycle with in_valid&&in_ready; byte index 0..8 writes A00..A22 and index 9..17 writes B00..B22, both row-major.
REQ-017 Acceptance of byte index 17 at cycle t moves the FSM to START; mm_start=1 during cycle t+1 only.
REQ-018 WAIT lasts exactly RUN_CYCLES cycles, occupying t+2..t+1+RUN_CYCLES, timed by a 4-bit down-counter.
REQ-019 CAPTURE lasts one cycle, t+2+RUN_CYCLES, and latches c_flat into a 72-bit shadow register at the end of that cycle.
REQ-020 SEND: out_valid=1 from cycle t+3+RUN_CYCLES; out_data = shadow byte at the result index, C00 first and C22 last.
REQ-021 The result index advances only on a cycle with out_valid&&out_ready; while out_valid=1 and out_ready=0, out_data shall hold stable.
REQ-022 Acceptance of C22 returns the FSM to LOAD on the next cycle, with in_ready=1 and the byte index at 0.
REQ-023 In every state except LOAD, in_ready=0 and in_valid is ignored.
REQ-024 a_flat and b_flat change only on accepted bytes and hold their values through START, WAIT, CAPTURE and SEND.
REQ-025 c_flat is sampled only in CAPTURE; changes to c_flat during SEND shall not affect out_data.
REQ-026 out_valid=0 and mm_start=0 in every state not named for them above.

Reset
REQ-027 rst_n=0 forces the FSM to LOAD immediately, regardless of the current state.
REQ-028 Reset values: in_ready=1, out_valid=0, mm_start=0, busy=0, a_flat=0, b_flat=0, shadow register=0, out_data=0x00, all counters 0.
REQ-029 Reset asserted mid-transfer discards all partial input and output progress; the first byte accepted after reset is A00.

Configuration
REQ-030 Macro MATRIX_IO_ZERO_CANON_EN defined: any result byte equal to 0x80 (negative zero) is transmitted as 0x00; all other bytes pass unchanged.
REQ-031 MATRIX_IO_ZERO_CANON_EN undefined: result bytes are transmitted exactly as captured, including 0x80.

Verification
REQ-032 Reset, then bytes 0x01..0x12 with in_valid held high -> a_flat=0x010203040506070809, b_flat=0x0A0B0C0D0E0F101112; mm_start is a single pulse one cycle after byte 0x12 is accepted.
REQ-033 c_flat=0x112233445566778899 held, out_ready=1, RUN_CYCLES=9 -> out_valid rises 12 cycles after the last input acceptance; out_data sequence is 0x11,0x22,...,0x99; in_ready=1 one cycle after 0x99 is accepted.
REQ-034 out_ready=0 for 5 cycles while out_data=0x33 -> 0x33 and out_valid hold steady; the full sequence is received with no drop and no duplicate.
REQ-035 in_valid=1 with in_data=0xFF throughout WAIT and SEND -> in_ready=0; a_flat and b_flat are unchanged.
REQ-036 rst_n pulsed low after 4 result bytes -> out_valid=0 and busy=0 while rst_n is low; after release, byte 0x05 lands in A00 (a_flat[71:64]=0x05).
REQ-037 C00=0x80 in c_flat -> first out_data=0x00 with MATRIX_IO_ZERO_CANON_EN defined, 0x80 without it.
